// File: rtl/inv_mixcol_seq.sv
// Iterative (Inv)MixColumns engine: COLS_PER_CYCLE columns per BUSY cycle, in place in a work register.
// Optional build macro INV_MIXCOL_FWD_EN adds a fwd port selecting forward MixColumns.
module inv_mixcol_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
`ifdef INV_MIXCOL_FWD_EN
    ,
    input  logic         fwd
`endif
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
    // in_ready and out_valid are pure decodes of the registered FSM state.

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("inv_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [2:0] CPC3     = 3'(COLS_PER_CYCLE);
    localparam logic [2:0] LAST_COL = 3'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [1:0]   col;
    logic [127:0] work;
    logic [127:0] work_nxt;
    logic         fwd_mode;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic fm);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] m3 [4];
        for (int i = 0; i < 4; i++) begin
            a[i]   = c[31-8*i -: 8];
            x2[i]  = xt(a[i]);
            x4[i]  = xt(x2[i]);
            x8[i]  = xt(x4[i]);
            m9[i]  = x8[i] ^ a[i];
            m11[i] = x8[i] ^ x2[i] ^ a[i];
            m13[i] = x8[i] ^ x4[i] ^ a[i];
            m14[i] = x8[i] ^ x4[i] ^ x2[i];
            m3[i]  = x2[i] ^ a[i];
        end
        if (fm) begin
            return {x2[0] ^ m3[1] ^ a[2]  ^ a[3],
                    a[0]  ^ x2[1] ^ m3[2] ^ a[3],
                    a[0]  ^ a[1]  ^ x2[2] ^ m3[3],
                    m3[0] ^ a[1]  ^ a[2]  ^ x2[3]};
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

`ifdef INV_MIXCOL_FWD_EN
    logic fwd_q;
    assign fwd_mode = fwd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            fwd_q <= fwd;
        end
    end
`else
    assign fwd_mode = 1'b0;
`endif

    // Columns col .. col+COLS_PER_CYCLE-1 are rewritten; the rest pass through.
    always_comb begin
        work_nxt = work;
        for (int c = 0; c < 4; c++) begin
            if ({1'b0, col} <= 3'(c) && 3'(c) < ({1'b0, col} + CPC3)) begin
                work_nxt[127-32*c -: 32] = mix_col(work[127-32*c -: 32], fwd_mode);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= 2'd0;
            work      <= '0;
            out_state <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_state;
                        col   <= 2'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    // col stays at its final value so it never exceeds 4-COLS_PER_CYCLE.
                    if ({1'b0, col} == LAST_COL) begin
                        out_state <= work_nxt;
                        state     <= DONE;
                    end else begin
                        col <= col + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Scoreboard bench for inv_mixcol_seq: stimulus pushes expected results, a negedge monitor pops and compares.
// Build with +define+INV_MIXCOL_FWD_EN to exercise the forward-MixColumns mode as well.
module tb_inv_mixcol_seq;
    parameter int CPC = 1;
    localparam int LAT = 4 / CPC;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_state;
    logic         busy;
`ifdef INV_MIXCOL_FWD_EN
    logic         fwd = 1'b0;
`endif

    inv_mixcol_seq #(.COLS_PER_CYCLE(CPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
`ifdef INV_MIXCOL_FWD_EN
        ,
        .fwd       (fwd)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Each output row r uses the first row of the circulant matrix rotated right by r.
    function automatic logic [W-1:0] ref_mix(input logic [W-1:0] s, input logic f);
        logic [7:0] inv_c [4];
        logic [7:0] fwd_c [4];
        logic [7:0] acc;
        logic [7:0] k;
        logic [W-1:0] r;
        inv_c = '{8'd14, 8'd11, 8'd13, 8'd9};
        fwd_c = '{8'd2, 8'd3, 8'd1, 8'd1};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    k = f ? fwd_c[(j - row + 4) % 4] : inv_c[(j - row + 4) % 4];
                    acc = acc ^ gf_mul(s[127-32*c-8*j -: 8], k);
                end
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int unsigned  acc_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    bit           b2b = 1'b0;
    bit           have_last = 1'b0;
    int unsigned  last_out = 0;
    logic         prev_ov = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        int unsigned a;
        logic [W-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
            have_last = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    fail_now("spurious_out_valid");
                end else begin
                    a = acc_q.pop_front();
                    chk("latency", W'(cyc - a), W'(LAT));
                end
                // Steady state: one cycle in IDLE, LAT in BUSY, one in DONE.
                if (b2b && have_last) chk("b2b_period", W'(cyc - last_out), W'(LAT + 2));
                last_out = cyc;
                have_last = b2b;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", out_state, e);
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] d, input logic f, input logic [W-1:0] exp);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_state = d;
`ifdef INV_MIXCOL_FWD_EN
        fwd = f;
`endif
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                fail_now("send_timeout");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        exp_q.push_back(exp);
        acc_q.push_back(cyc + 1);
        @(posedge clk); #1;
    endtask

    task automatic send_model(input logic [W-1:0] d, input logic f);
        send(d, f, ref_mix(d, f));
    endtask

    task automatic drain(input bit rnd_ready);
        int n;
        n = 0;
        in_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) break;
            n++;
            if (n > 500) begin
                fail_now("drain_timeout");
                break;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] held;
        int n;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_state", out_state, 0);
        chk("reset_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);

        // Known vectors.
        out_ready = 1'b1;
        send({4{32'h8e4da1bc}}, 1'b0, {4{32'hdb135345}});
        drain(1'b0);
        send({32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}, 1'b0,
             {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5});
        drain(1'b0);

`ifdef INV_MIXCOL_FWD_EN
        send({4{32'hdb135345}}, 1'b1, {4{32'h8e4da1bc}});
        drain(1'b0);
        send({4{32'hdb135345}}, 1'b0, ref_mix({4{32'hdb135345}}, 1'b0));
        drain(1'b0);
`endif

        // Stall in DONE: output held, no new acceptance.
        out_ready = 1'b0;
        send_model(rnd128(), 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("stall_wait_timeout");
        held = (exp_q.size() > 0) ? exp_q[0] : '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_state = rnd128();
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_state", out_state, held);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_busy", busy, 1);
        end
        drain(1'b0);

        // Random states with random back-pressure.
        for (int i = 0; i < 20; i++) begin
`ifdef INV_MIXCOL_FWD_EN
            send_model(rnd128(), 1'($urandom_range(0, 1)));
`else
            send_model(rnd128(), 1'b0);
`endif
            drain(1'b1);
        end

        // Back-to-back with in_valid held and out_ready tied high.
        out_ready = 1'b1;
        b2b = 1'b1;
        for (int i = 0; i < 6; i++) send_model(rnd128(), 1'b0);
        drain(1'b0);
        b2b = 1'b0;

        // Reset in the middle of an operation.
        out_ready = 1'b0;
        send_model(rnd128(), 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midop_rst_out_valid", out_valid, 0);
        chk("midop_rst_out_state", out_state, 0);
        chk("midop_rst_busy", busy, 0);
        chk("midop_rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_in_ready", in_ready, 1);
        chk("after_rst_out_valid", out_valid, 0);
        out_ready = 1'b1;
        send({4{32'h8e4da1bc}}, 1'b0, {4{32'hdb135345}});
        drain(1'b0);

        repeat (3) @(posedge clk);
        chk("queue_empty", W'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
